// File: rtl/f1_pkg.sv
// ---------------------------------------------------------------------------
// f1_pkg
// Shared types and helpers for the F1 start-light sequencer.
//   f1_state_t : sequencer states (IDLE, FILL, HOLD, GO)
//   MAX_LIGHTS : widest lamp vector the sequencer supports
//   THERMO_IN_W: width of the lamp-count argument taken by thermo()
//   thermo(n)  : MAX_LIGHTS-bit vector with the n low bits set; callers keep
//                the low N_LIGHTS bits they actually drive
// ---------------------------------------------------------------------------
package f1_pkg;

  localparam int MAX_LIGHTS  = 32;
  localparam int THERMO_IN_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    GO   = 2'd3
  } f1_state_t;

  // Thermometer code: lamp i is lit when fewer than n lamps precede it, so
  // bit0 lights first and the vector fills upwards as n grows.
  function automatic logic [MAX_LIGHTS-1:0] thermo(input logic [THERMO_IN_W-1:0] n);
    logic [MAX_LIGHTS-1:0] t;
    t = '0;
    for (int i = 0; i < MAX_LIGHTS; i++) begin
      t[i] = (i < int'(n));
    end
    return t;
  endfunction

endpackage

// File: rtl/f1_hold_counter.sv
// ---------------------------------------------------------------------------
// f1_hold_counter
// Loadable down-counter that times the all-lamps-lit hold phase.
// Ports:
//   clk      in  1  clock, all updates on posedge
//   rst      in  1  synchronous reset, active-low (0 clears the count)
//   load     in  1  load load_val (wins over dec)
//   load_val in  W  value to load
//   dec      in  1  decrement by one; ignored once the count is zero
//   cnt      out W  current count
//   last     out 1  high while cnt <= 1, i.e. the next tick ends the hold
// ---------------------------------------------------------------------------
module f1_hold_counter
  import f1_pkg::*;
#(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: a load always wins; a decrement stops at zero so the
  // counter can never wrap round to its maximum value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A loaded zero is treated like a one, which makes a zero-length hold
  // still last one tick.
  assign cnt  = cnt_q;
  assign last = (cnt_q <= W'(1));

endmodule

// File: rtl/f1_light_seq.sv
// ---------------------------------------------------------------------------
// f1_light_seq
// F1 start-light sequencer. A trigger in IDLE starts a sequence that lights
// one lamp per en tick (bit0 first), holds every lamp lit for a captured
// number of ticks, then blanks the lamps and pulses go for one clock.
// abort cancels a running sequence without a go pulse.
// Parameters:
//   N_LIGHTS  number of lamps, 1..32
//   DELAY_W   width of the hold-length input, in en ticks
// Ports:
//   clk       in  1         clock
//   rst       in  1         synchronous reset, active-low
//   en        in  1         step tick strobe, advances FILL and HOLD
//   trigger   in  1         start request, only looked at in IDLE
//   abort     in  1         cancel; returns to IDLE with lamps off
//   delay_in  in  DELAY_W   hold length, captured when a trigger is accepted
//   data_out  out N_LIGHTS  lamp vector, thermometer of lit_cnt
//   lit_cnt   out CW        number of lamps lit
//   busy      out 1         high in FILL and HOLD
//   go        out 1         one-clock pulse when the sequence completes
// ---------------------------------------------------------------------------
module f1_light_seq
  import f1_pkg::*;
#(
  parameter  int N_LIGHTS = 8,
  parameter  int DELAY_W  = 7,
  localparam int CW       = $clog2(N_LIGHTS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                trigger,
  input  logic                abort,
  input  logic [DELAY_W-1:0]  delay_in,
  output logic [N_LIGHTS-1:0] data_out,
  output logic [CW-1:0]       lit_cnt,
  output logic                busy,
  output logic                go
);

  localparam logic [CW-1:0] FULL_CNT = CW'(N_LIGHTS);

  f1_state_t            state_q;
  f1_state_t            state_d;
  logic [CW-1:0]        litCnt_q;
  logic [CW-1:0]        litCnt_d;
  logic [N_LIGHTS-1:0]  dataOut_q;
  logic [N_LIGHTS-1:0]  dataOut_d;
  logic [DELAY_W-1:0]   delay_q;
  logic [DELAY_W-1:0]   delay_d;
  logic                 busy_q;
  logic                 busy_d;
  logic                 go_q;
  logic                 go_d;

  logic                 holdLoad;
  logic                 holdDec;
  logic [DELAY_W-1:0]   holdCnt;
  logic                 holdLast;

  // Hold timer. It is loaded with the captured delay on the tick that lights
  // the final lamp and counts down on each en tick while in HOLD.
  f1_hold_counter #(
    .W (DELAY_W)
  ) u_hold_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (holdLoad),
    .load_val (delay_q),
    .dec      (holdDec),
    .cnt      (holdCnt),
    .last     (holdLast)
  );

  // Next-state and next-output logic. An abort outside IDLE beats everything
  // else; in IDLE it only blocks a trigger in the same cycle. Every output is
  // derived from the next state and count so that all of them come straight
  // off flops.
  always_comb begin
    state_d  = state_q;
    litCnt_d = litCnt_q;
    delay_d  = delay_q;
    holdLoad = 1'b0;
    holdDec  = 1'b0;

    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      litCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          litCnt_d = '0;
          if (trigger && !abort) begin
            state_d = FILL;
            delay_d = delay_in;
          end
        end

        FILL: begin
          if (en) begin
            if (litCnt_q >= (FULL_CNT - CW'(1))) begin
              litCnt_d = FULL_CNT;
              state_d  = HOLD;
              holdLoad = 1'b1;
            end else begin
              litCnt_d = litCnt_q + CW'(1);
            end
          end
        end

        HOLD: begin
          litCnt_d = FULL_CNT;
          if (en) begin
            if (holdLast) begin
              state_d  = GO;
              litCnt_d = '0;
            end else begin
              holdDec = (holdCnt != '0);
            end
          end
        end

        GO: begin
          state_d  = IDLE;
          litCnt_d = '0;
        end

        default: begin
          state_d  = IDLE;
          litCnt_d = '0;
        end
      endcase
    end

    dataOut_d = N_LIGHTS'(thermo(THERMO_IN_W'(litCnt_d)));
    busy_d    = (state_d == FILL) || (state_d == HOLD);
    go_d      = (state_d == GO);
  end

  // State and output registers, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      litCnt_q  <= '0;
      dataOut_q <= '0;
      delay_q   <= '0;
      busy_q    <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      litCnt_q  <= litCnt_d;
      dataOut_q <= dataOut_d;
      delay_q   <= delay_d;
      busy_q    <= busy_d;
      go_q      <= go_d;
    end
  end

  assign data_out = dataOut_q;
  assign lit_cnt  = litCnt_q;
  assign busy     = busy_q;
  assign go       = go_q;

endmodule

// File: tb/tb_f1_light_seq.sv
// ---------------------------------------------------------------------------
// tb_f1_light_seq
// Drives an 8-lamp and a 1-lamp sequencer from the same control inputs. A
// behavioural model of the light sequence pushes the expected outputs for
// every driven clock into a queue per instance; a monitor pops and compares
// them after each clock edge. Directed checks add go-pulse counts, hold
// lengths and abort behaviour.
// ---------------------------------------------------------------------------
module tb_f1_light_seq;

  typedef struct {
    int st;
    int lit;
    int cnt;
    int dly;
  } mdl_t;

  typedef struct {
    logic [31:0] data;
    int          lit;
    bit          busy;
    bit          go;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       trigger;
  logic       abort;
  logic [6:0] delayIn;
  logic [0:0] delayIn1;

  logic [7:0] data8;
  logic [3:0] lit8;
  logic       busy8;
  logic       go8;
  logic [0:0] data1;
  logic [0:0] lit1;
  logic       busy1;
  logic       go1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   goCount8 = 0;
  int   goCount1 = 0;
  mdl_t m8 = '{default: 0};
  mdl_t m1 = '{default: 0};
  exp_t q8[$];
  exp_t q1[$];
  exp_t e8;
  exp_t e1;

  assign delayIn1 = delayIn[0];

  // Clock generator, 10 time-unit period.
  always #5 clk = ~clk;

  f1_light_seq #(
    .N_LIGHTS (8),
    .DELAY_W  (7)
  ) dut8 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trigger  (trigger),
    .abort    (abort),
    .delay_in (delayIn),
    .data_out (data8),
    .lit_cnt  (lit8),
    .busy     (busy8),
    .go       (go8)
  );

  f1_light_seq #(
    .N_LIGHTS (1),
    .DELAY_W  (1)
  ) dut1 (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .trigger  (trigger),
    .abort    (abort),
    .delay_in (delayIn1),
    .data_out (data1),
    .lit_cnt  (lit1),
    .busy     (busy1),
    .go       (go1)
  );

  // Compare one observed value with its expected value and count the result.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Behavioural model of one clock of the sequencer.
  function automatic mdl_t modelStep(mdl_t m, int n, int dmask, bit rstn,
                                     bit trig, bit enV, bit ab, int dIn);
    mdl_t r;
    r = m;
    if (!rstn) begin
      r = '{default: 0};
    end else if (ab && (m.st != 0)) begin
      r.st  = 0;
      r.lit = 0;
    end else begin
      case (m.st)
        0: if (trig && !ab) begin
          r.st  = 1;
          r.lit = 0;
          r.dly = dIn & dmask;
        end
        1: if (enV) begin
          r.lit = m.lit + 1;
          if (r.lit == n) begin
            r.st  = 2;
            r.cnt = m.dly;
          end
        end
        2: if (enV) begin
          if (m.cnt <= 1) begin
            r.st  = 3;
            r.lit = 0;
          end else begin
            r.cnt = m.cnt - 1;
          end
        end
        default: begin
          r.st  = 0;
          r.lit = 0;
        end
      endcase
    end
    return r;
  endfunction

  // Expected pin values for a model state.
  function automatic exp_t expOf(mdl_t m);
    exp_t e;
    e.data = 32'((64'd1 << m.lit) - 64'd1);
    e.lit  = m.lit;
    e.busy = (m.st == 1) || (m.st == 2);
    e.go   = (m.st == 3);
    return e;
  endfunction

  // Drive one clock of stimulus on the falling edge, queue the expected
  // results for both instances, and return just after the rising edge.
  task automatic applyStimulus(input bit rstn, input bit trig, input bit enV,
                               input bit ab, input logic [6:0] dly);
    @(negedge clk);
    rst     = rstn;
    trigger = trig;
    en      = enV;
    abort   = ab;
    delayIn = dly;
    m8 = modelStep(m8, 8, 'h7f, rstn, trig, enV, ab, int'(dly));
    m1 = modelStep(m1, 1, 'h1, rstn, trig, enV, ab, int'(dly));
    q8.push_back(expOf(m8));
    q1.push_back(expOf(m1));
    cyc++;
    @(posedge clk);
    #2;
  endtask

  // One clock with en on every fourth cycle.
  task automatic tickStep(input bit trig, input bit ab, input logic [6:0] dly);
    applyStimulus(1'b1, trig, (cyc % 4) == 3, ab, dly);
  endtask

  // Run until the chosen instance pulses go, counting en ticks taken while
  // every lamp was already lit.
  task automatic runUntilGo(input int sel, input int maxSteps, output int ticks);
    bit done;
    bit full;
    bit enNow;
    done  = 1'b0;
    ticks = 0;
    for (int i = 0; i < maxSteps && !done; i++) begin
      full  = (sel == 0) ? (data8 == 8'hFF) : (data1 == 1'b1);
      enNow = (cyc % 4) == 3;
      applyStimulus(1'b1, 1'b0, enNow, 1'b0, 7'h2a);
      if (full && enNow) ticks++;
      if (((sel == 0) ? go8 : go1) === 1'b1) done = 1'b1;
    end
    if (!done) checkOutput("goTimeout", 32'd0, 32'd1);
  endtask

  // Scoreboard monitor: pop the expected values for this edge and compare.
  always @(posedge clk) begin
    #1;
    if (q8.size() > 0) begin
      e8 = q8.pop_front();
      checkOutput("data8", 32'(data8), e8.data);
      checkOutput("lit8", 32'(lit8), 32'(e8.lit));
      checkOutput("busy8", 32'(busy8), 32'(e8.busy));
      checkOutput("go8", 32'(go8), 32'(e8.go));
      if (go8 === 1'b1) goCount8++;
    end
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      checkOutput("data1", 32'(data1), e1.data);
      checkOutput("lit1", 32'(lit1), 32'(e1.lit));
      checkOutput("busy1", 32'(busy1), 32'(e1.busy));
      checkOutput("go1", 32'(go1), 32'(e1.go));
      if (go1 === 1'b1) goCount1++;
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int t;
    int g0;
    int g1;
    bit hit;

    rst = 1'b1; en = 1'b0; trigger = 1'b0; abort = 1'b0; delayIn = '0;

    $display("[TB] reset with trigger and en held high");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd5);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 7'd5);
    checkOutput("rstData", 32'(data8), 32'd0);
    checkOutput("rstBusy", 32'(busy8), 32'd0);
    checkOutput("rstGo", 32'(go8), 32'd0);
    for (int i = 0; i < 3; i++) tickStep(1'b0, 1'b0, 7'd0);

    $display("[TB] full sequence with hold of 3");
    g0 = goCount8;
    tickStep(1'b1, 1'b0, 7'd3);
    checkOutput("trigBusy", 32'(busy8), 32'd1);
    runUntilGo(0, 200, t);
    checkOutput("hold3", 32'(t), 32'd3);
    checkOutput("goData", 32'(data8), 32'd0);
    for (int i = 0; i < 6; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("goOnce", 32'(goCount8 - g0), 32'd1);

    $display("[TB] zero hold with en frozen mid fill");
    tickStep(1'b1, 1'b0, 7'd0);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tickStep(1'b0, 1'b0, 7'd0);
      hit = (lit8 == 4'd3);
    end
    checkOutput("reach3", 32'(lit8), 32'd3);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 7'h11);
    checkOutput("freeze", 32'(data8), 32'h07);
    runUntilGo(0, 200, t);
    checkOutput("hold0", 32'(t), 32'd1);
    for (int i = 0; i < 4; i++) tickStep(1'b0, 1'b0, 7'd0);

    $display("[TB] abort during fill");
    g0 = goCount8;
    tickStep(1'b1, 1'b0, 7'd3);
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      tickStep(1'b0, 1'b0, 7'd0);
      hit = (lit8 == 4'd5);
    end
    checkOutput("reach5", 32'(lit8), 32'd5);
    tickStep(1'b0, 1'b1, 7'd0);
    checkOutput("abFillData", 32'(data8), 32'd0);
    checkOutput("abFillBusy", 32'(busy8), 32'd0);
    for (int i = 0; i < 60; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("abFillNoGo", 32'(goCount8 - g0), 32'd0);

    $display("[TB] abort during hold");
    tickStep(1'b1, 1'b0, 7'd5);
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      tickStep(1'b0, 1'b0, 7'd0);
      hit = (data8 == 8'hFF);
    end
    checkOutput("reachFull", 32'(data8), 32'hFF);
    tickStep(1'b0, 1'b1, 7'd0);
    checkOutput("abHoldData", 32'(data8), 32'd0);
    checkOutput("abHoldBusy", 32'(busy8), 32'd0);
    for (int i = 0; i < 40; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("abHoldNoGo", 32'(goCount8 - g0), 32'd0);

    $display("[TB] abort together with trigger in idle");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 7'd3);
    checkOutput("abIdleBusy", 32'(busy8), 32'd0);
    for (int i = 0; i < 8; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("abIdleStay", 32'(busy8), 32'd0);

    $display("[TB] trigger during hold is ignored");
    g0 = goCount8;
    tickStep(1'b1, 1'b0, 7'd3);
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      tickStep(1'b0, 1'b0, 7'd0);
      hit = (data8 == 8'hFF);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 7'd99);
    runUntilGo(0, 200, t);
    checkOutput("holdKept", 32'(t), 32'd3);
    for (int i = 0; i < 20; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("oneGo", 32'(goCount8 - g0), 32'd1);

    $display("[TB] single lamp instance with hold of 1");
    g1 = goCount1;
    tickStep(1'b1, 1'b0, 7'd1);
    runUntilGo(1, 40, t);
    checkOutput("hold1Lamp", 32'(t), 32'd1);
    checkOutput("goData1", 32'(data1), 32'd0);
    tickStep(1'b0, 1'b1, 7'd0);
    for (int i = 0; i < 8; i++) tickStep(1'b0, 1'b0, 7'd0);
    checkOutput("oneGo1", 32'(goCount1 - g1), 32'd1);

    checkOutput("q8Empty", 32'(q8.size()), 32'd0);
    checkOutput("q1Empty", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
